// File: rtl/lpf_frame_sequencer.sv
// Frame sequencer feeding the 3x3 low-pass filter: load phase, process phase, and output capture.
// Optional 16-bit output checksum accumulator is enabled by defining LPF_SEQ_CHECKSUM_EN.
module lpf_frame_sequencer #(
  parameter int DEPTH = 410,
  parameter int WIDTH = 361
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        proc_hold,
  output logic        filt_clr,
  output logic [7:0]  filt_pix,
  output logic        filt_en,
  output logic        filt_proc,
  input  logic [7:0]  filt_in,
  output logic [7:0]  out_pix,
  output logic        out_valid,
  output logic [31:0] out_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  localparam logic [31:0] FRAME = 32'(WIDTH * DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_GAP, S_PROC, S_FLUSH, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] proc_cnt_q, proc_cnt_d;
  logic [31:0] out_idx_q, out_idx_d;
  logic        flush_q, flush_d;
  logic        byte_ready_q, byte_ready_d;
  logic        filt_clr_q, filt_clr_d;
  logic [7:0]  filt_pix_q, filt_pix_d;
  logic        filt_en_q, filt_en_d;
  logic        filt_proc_q, filt_proc_d;
  logic        vld_p1_q, vld_p1_d;
  logic [7:0]  out_pix_q, out_pix_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hs;
  logic        frame_start;

  assign frame_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    // proc_cnt counts every cycle filt_proc was actually driven high
    proc_cnt_d = proc_cnt_q + {31'd0, filt_proc_q};
    out_idx_d  = out_idx_q + {31'd0, out_valid_q};
    flush_d    = flush_q;
    filt_pix_d = filt_pix_q;
    filt_en_d  = 1'b0;
    hs         = byte_valid && byte_ready_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (frame_start) begin
          state_d    = S_CLR;
          load_cnt_d = '0;
          proc_cnt_d = '0;
          out_idx_d  = '0;
        end
      end
      S_CLR:   state_d = S_LOAD;
      S_LOAD: begin
        if (hs) begin
          filt_pix_d = byte_in;
          filt_en_d  = 1'b1;
          load_cnt_d = load_cnt_q + 32'd1;
          if (load_cnt_d == FRAME) state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_PROC;
      S_PROC: begin
        flush_d = 1'b0;
        if (proc_cnt_d == FRAME) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Two cycles cover the filter latency plus the capture register
        flush_d = 1'b1;
        if (flush_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    byte_ready_d = (state_d == S_LOAD) && (load_cnt_d < FRAME);
    filt_clr_d   = (state_d == S_CLR);
    filt_proc_d  = (state_d == S_PROC) && !proc_hold && (proc_cnt_d < FRAME);
    vld_p1_d     = filt_proc_q;
    out_valid_d  = vld_p1_q;
    out_pix_d    = vld_p1_q ? filt_in : out_pix_q;
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      proc_cnt_q   <= '0;
      out_idx_q    <= '0;
      flush_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      filt_clr_q   <= 1'b0;
      filt_pix_q   <= '0;
      filt_en_q    <= 1'b0;
      filt_proc_q  <= 1'b0;
      vld_p1_q     <= 1'b0;
      out_pix_q    <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      proc_cnt_q   <= proc_cnt_d;
      out_idx_q    <= out_idx_d;
      flush_q      <= flush_d;
      byte_ready_q <= byte_ready_d;
      filt_clr_q   <= filt_clr_d;
      filt_pix_q   <= filt_pix_d;
      filt_en_q    <= filt_en_d;
      filt_proc_q  <= filt_proc_d;
      // stage p1: filter output valid; stage p2: captured pixel presented
      vld_p1_q     <= vld_p1_d;
      out_pix_q    <= out_pix_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef LPF_SEQ_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (frame_start)   sum_d = '0;
    else if (vld_p1_q) sum_d = sum_q + {8'd0, filt_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign byte_ready = byte_ready_q;
  assign filt_clr   = filt_clr_q;
  assign filt_pix   = filt_pix_q;
  assign filt_en    = filt_en_q;
  assign filt_proc  = filt_proc_q;
  assign out_pix    = out_pix_q;
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lpf_frame_sequencer.sv
// Testbench for lpf_frame_sequencer (FRAME=12); expected checksum follows LPF_SEQ_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_lpf_frame_sequencer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 3;
  localparam int FRAME = DEPTH * WIDTH;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid, proc_hold;
  logic [7:0]  byte_in, filt_in;
  logic        byte_ready, filt_clr, filt_en, filt_proc, out_valid, busy, done;
  logic [7:0]  filt_pix, out_pix;
  logic [31:0] out_idx;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  lpf_frame_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .proc_hold(proc_hold), .filt_clr(filt_clr), .filt_pix(filt_pix),
    .filt_en(filt_en), .filt_proc(filt_proc), .filt_in(filt_in),
    .out_pix(out_pix), .out_valid(out_valid), .out_idx(out_idx),
    .busy(busy), .done(done), .checksum(checksum)
  );

  // vmode: 0 valid always, 1 toggling, 2 random; hmode: 0 none, 1 window, 2 random
  typedef struct {
    int vmode;
    int hmode;
    int hlo;
    int hhi;
    int fconst;
    int abort_at;
    int exp_gap;
    int exp_sum;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   prev_done = 1'b0;

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".filt_clr"},   -1, 32'(filt_clr),   0);
    chk({tag, ".filt_en"},    -1, 32'(filt_en),    0);
    chk({tag, ".filt_proc"},  -1, 32'(filt_proc),  0);
    chk({tag, ".byte_ready"}, -1, 32'(byte_ready), 0);
    chk({tag, ".out_valid"},  -1, 32'(out_valid),  0);
    chk({tag, ".done"},       -1, 32'(done),       0);
    chk({tag, ".busy"},       -1, 32'(busy),       0);
    chk({tag, ".out_pix"},    -1, 32'(out_pix),    0);
    chk({tag, ".out_idx"},    -1, out_idx,         0);
    chk({tag, ".filt_pix"},   -1, 32'(filt_pix),   0);
    chk({tag, ".checksum"},   -1, 32'(checksum),   0);
  endtask

  task automatic run_frame(input vec_t v);
    int vals[FRAME];
    int c = 0, acc = 0, issued = 0, outs = 0, P = -1, M = -1, fidx = 0;
    int frame_sum = 0, act_procs = 0, act_outs = 0, gaps = 0, pending = 0;
    bit prev_hs = 0, hs, cur_hold = 0, prev_hold = 0, cur_valid = 0;
    bit p1 = 0, p2 = 0, exp_proc, exp_ready, exp_done, act_proc_prev = 0;
    bit seen_proc = 0, aborted = 0, finished = 0;
    logic [7:0] last_byte = 8'd0, cur_byte = 8'd0;
    int exp_final;

    for (int i = 0; i < FRAME; i++) vals[i] = (v.fconst != 0) ? 8'h80 : int'($urandom_range(0, 255));

    @(posedge clk); #1;
    start = 1'b1; byte_valid = 1'b0; proc_hold = 1'b0;

    for (int guard = 0; guard < 400; guard++) begin
      @(negedge clk);
      exp_ready = (c >= 2) && (acc < FRAME);
      hs        = cur_valid && exp_ready;
      exp_proc  = (P >= 0) && (c >= P) && !prev_hold && (issued < FRAME);
      exp_done  = (c == 0) ? prev_done : ((M >= 0) && (c >= M + 3));

      chk("byte_ready", c, 32'(byte_ready), 32'(exp_ready));
      chk("filt_clr",   c, 32'(filt_clr),   32'(c == 1));
      chk("filt_en",    c, 32'(filt_en),    32'(prev_hs));
      if (prev_hs) chk("filt_pix", c, 32'(filt_pix), 32'(last_byte));
      chk("filt_proc",  c, 32'(filt_proc),  32'(exp_proc));
      chk("out_valid",  c, 32'(out_valid),  32'(p2));
      if (p2) begin
        frame_sum = (frame_sum + vals[outs]) & 32'hFFFF;
        chk("out_idx", c, out_idx, 32'(outs));
        chk("out_pix", c, 32'(out_pix), 32'(vals[outs]));
        outs++;
      end
      chk("done", c, 32'(done), 32'(exp_done));
      chk("busy", c, 32'(busy), 32'((c >= 1) && !exp_done));
`ifdef LPF_SEQ_CHECKSUM_EN
      if (c >= 1) chk("checksum", c, 32'(checksum), 32'(frame_sum));
`else
      if (c >= 1) chk("checksum", c, 32'(checksum), 0);
`endif

      if (filt_proc) begin
        act_procs++;
        if (seen_proc) gaps += pending;
        pending = 0;
        seen_proc = 1;
      end else if (seen_proc) begin
        pending++;
      end
      if (out_valid) act_outs++;
      act_proc_prev = filt_proc;

      if (hs) begin
        acc++;
        last_byte = cur_byte;
        if (acc == FRAME) P = c + 2;
      end
      prev_hs = hs;
      if (exp_proc) begin
        issued++;
        if (issued == FRAME) M = c;
      end
      p2 = p1;
      p1 = exp_proc;

      if (v.abort_at >= 0 && issued == v.abort_at) begin aborted = 1; break; end
      if (M >= 0 && c == M + 4) begin finished = 1; break; end

      @(posedge clk); #1;
      c++;
      start = 1'b0;
      prev_hold = cur_hold;
      case (v.vmode)
        0:       cur_valid = (c >= 1);
        1:       cur_valid = (c % 2 == 0);
        default: cur_valid = ($urandom_range(0, 1) == 1);
      endcase
      cur_byte = (v.vmode == 2) ? 8'($urandom_range(0, 255)) : 8'(acc + 1);
      case (v.hmode)
        0:       cur_hold = 1'b0;
        1:       cur_hold = (P >= 0) && (c - P >= v.hlo) && (c - P <= v.hhi);
        default: cur_hold = ($urandom_range(0, 3) == 0);
      endcase
      byte_valid = cur_valid;
      byte_in    = cur_byte;
      proc_hold  = cur_hold;
      // Filter model: output becomes valid the cycle after filt_proc
      if (act_proc_prev) begin
        filt_in = 8'(vals[(fidx < FRAME) ? fidx : FRAME - 1]);
        fidx++;
      end else begin
        filt_in = (v.fconst != 0) ? 8'h80 : 8'($urandom_range(0, 255));
      end
    end

    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1;
      #1;
      chk_zero_outputs("abort");
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; byte_valid = 1'b0; proc_hold = 1'b0;
      @(negedge clk);
      chk("post_abort.busy",     c, 32'(busy),     0);
      chk("post_abort.filt_clr", c, 32'(filt_clr), 0);
      chk("post_abort.done",     c, 32'(done),     0);
      prev_done = 1'b0;
    end else if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout cyc=%0d got=issued %0d exp=%0d", c, issued, FRAME);
      prev_done = done;
    end else begin
      chk("procs_total", c, 32'(act_procs), FRAME);
      chk("outs_total",  c, 32'(act_outs),  FRAME);
      if (v.exp_gap >= 0) chk("hold_gap", c, 32'(gaps), 32'(v.exp_gap));
`ifdef LPF_SEQ_CHECKSUM_EN
      exp_final = (v.exp_sum >= 0) ? v.exp_sum : frame_sum;
`else
      exp_final = 0;
`endif
      chk("final_sum",  c, 32'(checksum), 32'(exp_final));
      chk("done_final", c, 32'(done), 1);
      prev_done = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'd0;
    proc_hold = 1'b0; filt_in = 8'd0;

    //         vmode hmode hlo hhi fconst abort gap  sum
    vecs[0] = '{0,    0,    0,  0,  1,     -1,   0,   'h0600};
    vecs[1] = '{1,    1,    3,  5,  0,     -1,   3,   -1};
    vecs[2] = '{0,    1,    3,  5,  1,     -1,   3,   'h0600};
    vecs[3] = '{2,    2,    0,  0,  0,     -1,   -1,  -1};
    vecs[4] = '{0,    0,    0,  0,  0,     5,    -1,  -1};
    vecs[5] = '{2,    2,    0,  0,  0,     -1,   -1,  -1};
    vecs[6] = '{1,    0,    0,  0,  1,     -1,   0,   'h0600};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle.busy", -1, 32'(busy), 0);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
